// File: rtl/sram_pkg.sv
// Shared types and helpers for the simple dual-port SRAM family.
// be_merge works at a fixed maximum width; callers size-cast in and out.
package sram_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int MAX_DW  = 1024;

  function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0]   old_w,
                                                 input logic [MAX_DW-1:0]   new_w,
                                                 input logic [MAX_DW/8-1:0] be);
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int k = 0; k < MAX_DW/8; k++) begin
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// READ_LATENCY-deep delay of {valid, err, data}; data stages only load on a
// valid beat so the output holds its last value between beats.
module sram_rd_pipe #(
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic          err_i,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  output logic          err_o,
  output logic [DW-1:0] data_o
);

  logic [LAT-1:0]         vld_q;
  logic [LAT-1:0]         err_q;
  logic [LAT-1:0][DW-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q  <= '0;
      err_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      err_q[0] <= vld_i & err_i;
      if (vld_i) data_q[0] <= data_i;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        err_q[k] <= err_q[k-1];
        if (vld_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

  assign vld_o  = vld_q[LAT-1];
  assign err_o  = err_q[LAT-1];
  assign data_o = data_q[LAT-1];

endmodule

// File: rtl/sp_sram_dp.sv
// Simple dual-port SRAM: byte-enabled write port, pipelined read port,
// selectable read-during-write result and optional zeroing sweep after reset.
module sp_sram_dp
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int DEPTH         = 1024,
  parameter int READ_LATENCY  = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    ready_o,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_valid_o,
  output logic                    rd_err_o
);

  localparam int                  BE_WIDTH = DATA_WIDTH/8;
  localparam int                  IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IW-1:0]       LAST     = IW'(DEPTH-1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_dw
    $error("sp_sram_dp: DATA_WIDTH must be a multiple of 8 and <= MAX_DW");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_lat
    $error("sp_sram_dp: READ_LATENCY must be 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > (2**ADDR_WIDTH)) begin : g_bad_depth
    $error("sp_sram_dp: DEPTH must be in 1..2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  state_e                state_q, state_d;
  logic [IW-1:0]         cnt_q, cnt_d;

  logic                  wr_hit, rd_hit, run;
  logic [IW-1:0]         wr_idx, rd_idx, mem_wa;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wd, merged, rd_word;

  // Compare on the full port width so addresses >= DEPTH never alias.
  assign wr_hit = ({1'b0, wr_addr_i} < DEPTH_A);
  assign rd_hit = ({1'b0, rd_addr_i} < DEPTH_A);
  assign wr_idx = wr_addr_i[IW-1:0];
  assign rd_idx = rd_addr_i[IW-1:0];
  assign run    = (state_q == RUN);

  assign merged = DATA_WIDTH'(be_merge(MAX_DW'(mem_q[wr_idx]), MAX_DW'(wr_data_i),
                                       (MAX_DW/8)'(wr_be_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= (INIT_ON_RESET != 0) ? INIT : RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + IW'(1);
      if (cnt_q == LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  always_comb begin
    ready_o = run;
    mem_we  = 1'b0;
    mem_wa  = wr_idx;
    mem_wd  = merged;
    if (state_q == INIT) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
    end else if (wr_en_i && wr_hit) begin
      mem_we = 1'b1;
    end
  end

  // Storage is deliberately unreset; only the sweep clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_comb begin
    rd_word = '0;
    if (rd_hit) begin
      if (RDW_MODE == RDW_NEW && wr_en_i && wr_hit && wr_idx == rd_idx) rd_word = merged;
      else                                                            rd_word = mem_q[rd_idx];
    end
  end

  sram_rd_pipe #(
    .DW  (DATA_WIDTH),
    .LAT (READ_LATENCY)
  ) u_rd_pipe (
    .clk_i  (clk_i),
    .clr_i  (rst_i),
    .vld_i  (rd_en_i && run),
    .err_i  (!rd_hit),
    .data_i (rd_word),
    .vld_o  (rd_valid_o),
    .err_o  (rd_err_o),
    .data_o (rd_data_o)
  );

  logic unused_be_width;
  assign unused_be_width = (BE_WIDTH == 0);

endmodule

// File: tb/tb_sp_sram_dp.sv
// Three sp_sram_dp configurations driven by shared stimulus; per-instance
// scoreboards hold expected read beats keyed by the cycle they must appear.
module tb_sp_sram_dp;

  localparam int RLAT [3] = '{1, 2, 1};
  localparam int DEP  [3] = '{16, 16, 12};
  localparam bit INI  [3] = '{1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data;

  logic [2:0]  rdy, vld, err;
  logic [31:0] dat [3];

  always #5 clk = ~clk;

  sp_sram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(1),
               .RDW_MODE(0), .INIT_ON_RESET(1)) u0 (
    .clk_i(clk), .rst_i(rst), .ready_o(rdy[0]), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_be_i(wr_be), .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(dat[0]), .rd_valid_o(vld[0]), .rd_err_o(err[0]));

  sp_sram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(2),
               .RDW_MODE(1), .INIT_ON_RESET(1)) u1 (
    .clk_i(clk), .rst_i(rst), .ready_o(rdy[1]), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_be_i(wr_be), .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(dat[1]), .rd_valid_o(vld[1]), .rd_err_o(err[1]));

  sp_sram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(1),
               .RDW_MODE(0), .INIT_ON_RESET(0)) u2 (
    .clk_i(clk), .rst_i(rst), .ready_o(rdy[2]), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_be_i(wr_be), .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(dat[2]), .rd_valid_o(vld[2]), .rd_err_o(err[2]));

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [2:0][31:0] e;
    logic [2:0]  er;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } beat_t;

  beat_t       sb [3][$];
  int          cyc  = 0;
  int          nvec = 0;
  int          nerr = 0;
  bit          run_m [3];
  int          cnt_m [3];
  logic [31:0] last_d [3];
  vec_t        tbl [17];

  function automatic vec_t mk(logic we, logic [3:0] wa, logic [3:0] be, logic [31:0] wd,
                              logic re, logic [3:0] ra,
                              logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic er2);
    vec_t v;
    v.we = we; v.wa = wa; v.be = be; v.wd = wd; v.re = re; v.ra = ra;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
    v.er = {er2, 1'b0, 1'b0};
    return v;
  endfunction

  task automatic cmp(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", nm, d, cyc, got, exp);
    end
  endtask

  // Inputs are driven just after the negedge check; a read sampled at the
  // next edge must show up after edge cyc+READ_LATENCY.
  task automatic drive(input vec_t v);
    wr_en = v.we; wr_addr = v.wa; wr_be = v.be; wr_data = v.wd;
    rd_en = v.re; rd_addr = v.ra;
    for (int d = 0; d < 3; d++) begin
      if (v.re && !rst && run_m[d]) sb[d].push_back('{cyc + RLAT[d], v.e[d], v.er[d]});
    end
  endtask

  task automatic step();
    beat_t b;
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        run_m[d] = !INI[d];
        cnt_m[d] = 0;
        last_d[d] = '0;
        sb[d].delete();
      end else if (!run_m[d]) begin
        cnt_m[d]++;
        if (cnt_m[d] == DEP[d]) run_m[d] = 1'b1;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      cmp("ready", d, 32'(rdy[d]), 32'(run_m[d]));
      if (sb[d].size() != 0 && sb[d][0].due == cyc) begin
        b = sb[d].pop_front();
        cmp("rd_valid", d, 32'(vld[d]), 32'd1);
        cmp("rd_data",  d, dat[d], b.d);
        cmp("rd_err",   d, 32'(err[d]), 32'(b.e));
        last_d[d] = b.d;
      end else begin
        cmp("rd_valid_idle", d, 32'(vld[d]), 32'd0);
        cmp("rd_data_hold",  d, dat[d], last_d[d]);
      end
    end
  endtask

  task automatic sweep_check(input vec_t sw);
    for (int k = 1; k <= 16; k++) begin
      drive(sw);
      step();
      cmp("ready_rise", 0, 32'(rdy[0]), 32'(k >= 16));
      cmp("ready_rise", 1, 32'(rdy[1]), 32'(k >= 16));
    end
  endtask

  initial begin
    vec_t idle, sw;
    idle = mk(1'b0, 4'd0, 4'h0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    // Init-phase traffic: ignored by the sweeping instances, out of range for u2.
    sw   = mk(1'b1, 4'd13, 4'hF, 32'hFFFF_FFFF, 1'b1, 4'd13, 32'h0, 32'h0, 32'h0, 1'b1);

    tbl[0]  = mk(1, 4'd5,  4'hF, 32'h1122_3344, 0, 4'd0,  32'h0, 32'h0, 32'h0, 0);
    tbl[1]  = mk(1, 4'd5,  4'h5, 32'hAABB_CCDD, 1, 4'd13, 32'h0, 32'h0, 32'h0, 1);
    tbl[2]  = mk(0, 4'd0,  4'h0, 32'h0,         1, 4'd5,  32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 0);
    tbl[3]  = mk(1, 4'd3,  4'hF, 32'h0,         0, 4'd0,  32'h0, 32'h0, 32'h0, 0);
    tbl[4]  = mk(1, 4'd13, 4'hF, 32'hFFFF_FFFF, 0, 4'd0,  32'h0, 32'h0, 32'h0, 0);
    tbl[5]  = mk(1, 4'd3,  4'hF, 32'hDEAD_BEEF, 1, 4'd3,  32'h0, 32'hDEAD_BEEF, 32'h0, 0);
    tbl[6]  = mk(1, 4'd1,  4'hF, 32'hCAFE_F00D, 1, 4'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    tbl[7]  = mk(1, 4'd13, 4'hF, 32'hFFFF_FFFF, 1, 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1);
    tbl[8]  = mk(0, 4'd0,  4'h0, 32'h0,         1, 4'd1,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
    tbl[9]  = mk(1, 4'd5,  4'h0, 32'h0,         1, 4'd5,  32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 0);
    tbl[10] = mk(0, 4'd0,  4'h0, 32'h0,         1, 4'd5,  32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 0);
    tbl[11] = mk(1, 4'd6,  4'hF, 32'h1234_5678, 1, 4'd5,  32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD, 0);
    tbl[12] = mk(0, 4'd0,  4'h0, 32'h0,         1, 4'd6,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 0);
    tbl[13] = mk(1, 4'd5,  4'h2, 32'h0000_EE00, 1, 4'd5,  32'h11BB_33DD, 32'h11BB_EEDD, 32'h11BB_33DD, 0);
    tbl[14] = mk(0, 4'd0,  4'h0, 32'h0,         1, 4'd5,  32'h11BB_EEDD, 32'h11BB_EEDD, 32'h11BB_EEDD, 0);
    tbl[15] = mk(1, 4'd11, 4'hF, 32'h0BAD_C0DE, 1, 4'd12, 32'h0, 32'h0, 32'h0, 1);
    tbl[16] = mk(0, 4'd0,  4'h0, 32'h0,         1, 4'd11, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 0);

    for (int d = 0; d < 3; d++) begin
      run_m[d] = 1'b0; cnt_m[d] = 0; last_d[d] = '0;
    end

    rst = 1'b1;
    drive(idle);
    step();
    step();
    rst = 1'b0;
    sweep_check(sw);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i]);
      step();
    end
    drive(idle);
    step();

    for (int i = 0; i < 16; i++) begin
      drive(mk(1'b1, 4'(i), 4'hF, 32'(i*3), 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0));
      step();
    end
    for (int i = 0; i < 16; i++) begin
      drive(mk(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'(i), 32'(i*3), 32'(i*3),
               (i < 12) ? 32'(i*3) : 32'h0, 1'(i >= 12)));
      step();
    end
    drive(idle);
    repeat (3) step();

    // Reset lands while the two-stage instance still holds a beat in flight.
    drive(mk(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd1, 32'd3, 32'd3, 32'd3, 1'b0));
    step();
    rst = 1'b1;
    drive(mk(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd2, 32'd6, 32'd6, 32'd6, 1'b0));
    step();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(sw);
      step();
    end
    rst = 1'b1;
    drive(sw);
    step();
    rst = 1'b0;
    sweep_check(sw);

    drive(mk(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd1, 32'h0, 32'h0, 32'd3, 1'b0));
    step();
    drive(mk(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd13, 32'h0, 32'h0, 32'h0, 1'b1));
    step();
    drive(idle);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sp_sram_dp.md
Name: sp_sram_dp

Overview:
- Parametrised successor to the team's single-port SRAM model: simple dual-port memory with one write port and one read port, usable in the same cycle.
- Adds per-byte write enables, a configurable read pipeline depth, a selectable read-during-write policy and a reset-triggered zeroing sweep.
- Used as the generic on-chip buffer behind FIFOs, line buffers and register-file shadows. Behavioural RDL, synthesisable, with no vendor primitives.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address port width.
- DEPTH, 1024, number of words; DEPTH ≤ 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read request to data; legal values are 1 and 2.
- RDW_MODE, 0, same-address read-during-write result: 0 returns old data, 1 returns new (merged) data.
- INIT_ON_RESET, 1, 1 means reset starts a zeroing sweep of all DEPTH words.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  1 when the memory accepts accesses; 0 during the init sweep.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_be  in  DATA_WIDTH/8  byte enables; bit k covers data[8k+7:8k].
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_data  out  DATA_WIDTH  read data; valid when rd_valid=1.
- rd_valid  out  1  one-cycle strobe marking the rd_data beat.
- rd_err  out  1  qualifies rd_valid; 1 means out-of-range read.

Behaviour:
- Reset is sampled at the clk edge. In the reset cycle:
  - rd_valid=0, rd_err=0 and rd_data=0, including all internal pipeline stages.
  - The sweep counter clears to 0.
- State machine has two states, INIT and RUN.
  - Reset enters INIT if INIT_ON_RESET=1, otherwise RUN.
  - ready=0 in INIT and 1 in RUN. ready is registered, so its value right after the reset edge is 0 or 1 per INIT_ON_RESET.
- INIT:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - When the write to cnt=DEPTH-1 completes, move to RUN. ready=1 from the following cycle, exactly DEPTH cycles after reset deasserts.
  - wr_en and rd_en are ignored: no memory update, no rd_valid.
  - rst asserted mid-sweep restarts the sweep from cnt=0.
- Write (RUN):
  - On an edge with wr_en=1 and wr_addr<DEPTH, update only the bytes whose wr_be bit is 1.
  - wr_be=0 is a legal no-op.
  - wr_addr≥DEPTH drops the write silently; no wrap or alias.
- Read (RUN):
  - rd_en=1 at edge N: rd_valid=1 and rd_data present after edge N+READ_LATENCY-1, i.e. visible in the cycle after that edge.
  - One read may be issued per cycle, fully pipelined, no stalls.
  - rd_addr≥DEPTH gives rd_data=0 and rd_err=1 on that beat.
  - rd_data holds its last value while rd_valid=0.
- Read-during-write to the same in-range address on the same edge:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (new bytes where wr_be=1, old bytes elsewhere).
  - Different addresses never interact.
- Back-to-back dependency: a read one cycle after a write to the same address always sees the written data, in both modes.
- Reset mid-read: in-flight reads are discarded; no rd_valid emerges after reset.
- Memory contents are not cleared by reset when INIT_ON_RESET=0.
- Write port and read port are independent; both may fire every cycle.

Decomposition:
- Shared package sram_pkg:
  - State enum {INIT, RUN}.
  - RDW_OLD=0 and RDW_NEW=1 constants.
  - Function be_merge(old, new, be).
- Localparam BE_WIDTH = DATA_WIDTH/8 lives in the module.
- Elaboration-time assertions check DATA_WIDTH%8==0, READ_LATENCY∈{1,2} and DEPTH≤2**ADDR_WIDTH.
- One sub-module, sram_rd_pipe: parametrised READ_LATENCY delay of {valid, err, data} with synchronous clear.
- Storage array, init FSM and write merge stay in the top module.

Test Plan:
- Init sweep: DEPTH=16, INIT_ON_RESET=1; deassert rst, then read all 16 addresses → ready rises exactly 16 cycles after reset; every read returns 0 with rd_err=0.
- Byte enables:
  - Write 0x11223344 at addr 5 with be=4'hF, then write 0xAABBCCDD with be=4'b0101.
  - Read addr 5 → 0x11BB33DD after READ_LATENCY cycles, rd_valid high for exactly 1 cycle.
- RDW collision:
  - mem[3]=0x0; same edge: write 0xDEADBEEF with be=4'hF and read addr 3.
  - Expect 0x00000000 with RDW_MODE=0 and 0xDEADBEEF with RDW_MODE=1.
  - The next-cycle read returns 0xDEADBEEF in both modes.
- Pipelined streaming: READ_LATENCY=2; write addr i with data i*3 for i=0..15, then issue 16 back-to-back reads → 16 consecutive rd_valid beats, data 0,3,…,45, first beat 2 cycles after the first rd_en.
- Out of range: DEPTH=12, ADDR_WIDTH=4:
  - Write 0xFFFFFFFF to addr 13 → no memory change.
  - Read addr 13 → rd_data=0, rd_err=1.
  - Read addr 1 → unchanged value.
- Reset mid-operation:
  - Assert rst for 1 cycle at cnt=7 during the sweep → ready returns exactly DEPTH cycles later.
  - Assert rst with reads in flight → no rd_valid after reset; any rd_en issued during INIT yields no rd_valid.
